// File: rtl/rx_frame_buffer_pkg.sv
// rx_frame_buffer_pkg: shared types and constants for the RX store-and-forward frame buffer
//   wr_state_t : write-side FSM states (IDLE/RECV/DROP)
//   entry_t    : one RAM word, {last, data}
//   STAT_W     : width of the optional frame statistics counters
package rx_frame_buffer_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;
  localparam int STAT_W = 16;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port (BSRAM-friendly)
//   clock        : single clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re
module sdp_ram #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward RX frame buffer; releases only complete error-free frames
//   clock, aresetn          : clock and asynchronous active-low reset
//   s_tdata/tvalid/tready/tlast/tuser : AXI-Stream input from the MAC (tuser = error on tlast)
//   m_tdata/tvalid/tready/tlast       : AXI-Stream output of committed frames
//   drop_pulse              : one-cycle pulse per discarded frame (error or overflow)
//   stat_ok/err/ovf         : saturating frame counters, present only with RX_FRAME_BUFFER_STATS_EN
module rx_frame_buffer
  import rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              aresetn,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              drop_pulse
`ifdef RX_FRAME_BUFFER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_err,
  output logic [STAT_W-1:0] stat_ovf
`endif
);
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH);
  wr_state_t       state;
  logic [ADDR_W:0] wr_ptr, wr_cmt, rd_ptr;
  logic            beat, full, discard, we, re, rd_v, sk_v, held;
  entry_t          wdata, rdata, sk, head;
  assign beat    = s_tvalid & s_tready;
  assign full    = (wr_ptr - rd_ptr) == CAP;
  // once a frame has hit overflow every remaining beat of it is thrown away
  assign discard = (state == DROP) | full;
  assign we      = beat & ~discard;
  assign wdata   = '{last: s_tlast, data: s_tdata};
  assign held    = m_tvalid & ~m_tready;
  // keep head + skid + in-flight read to at most two live entries, so returning data always lands
  assign re      = (rd_ptr != wr_cmt) & ~((held & sk_v) | (held & rd_v) | (sk_v & rd_v));
  assign m_tdata = head.data;
  assign m_tlast = head.last;
  sdp_ram #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_ram (
    .clock(clock),
    .we(we),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(wdata),
    .re(re),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rdata)
  );
  // write FSM: wr_ptr runs ahead speculatively, wr_cmt marks what the reader may see
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_cmt     <= '0;
      drop_pulse <= 1'b0;
      s_tready   <= 1'b0;
    end else begin
      s_tready   <= 1'b1;
      drop_pulse <= 1'b0;
      if (beat) begin
        if (discard) begin
          wr_ptr     <= wr_cmt;
          state      <= s_tlast ? IDLE : DROP;
          drop_pulse <= s_tlast;
        end else if (s_tlast) begin
          state      <= IDLE;
          wr_ptr     <= s_tuser ? wr_cmt : wr_ptr + 1'b1;
          drop_pulse <= s_tuser;
          if (!s_tuser) wr_cmt <= wr_ptr + 1'b1;
        end else begin
          state  <= RECV;
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end
  // read side: RAM output feeds head register, skid catches the word still in flight on a stall
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr   <= '0;
      rd_v     <= 1'b0;
      sk_v     <= 1'b0;
      sk       <= '0;
      head     <= '0;
      m_tvalid <= 1'b0;
    end else begin
      rd_v <= re;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      if (!held) begin
        m_tvalid <= sk_v | rd_v;
        if (sk_v | rd_v) head <= sk_v ? sk : rdata;
        sk_v <= sk_v & rd_v;
        if (sk_v & rd_v) sk <= rdata;
      end else if (rd_v) begin
        sk_v <= 1'b1;
        sk   <= rdata;
      end
    end
  end
`ifdef RX_FRAME_BUFFER_STATS_EN
  logic ok_ev, err_ev, ovf_ev;
  assign ok_ev  = we & s_tlast & ~s_tuser;
  assign err_ev = we & s_tlast & s_tuser;
  assign ovf_ev = beat & discard & s_tlast;
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      stat_ok  <= '0;
      stat_err <= '0;
      stat_ovf <= '0;
    end else begin
      if (ok_ev && stat_ok != '1) stat_ok <= stat_ok + 1'b1;
      if (err_ev && stat_err != '1) stat_err <= stat_err + 1'b1;
      if (ovf_ev && stat_ovf != '1) stat_ovf <= stat_ovf + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: randomized self-checking bench for rx_frame_buffer against a frame-queue model
module tb_rx_frame_buffer;
  import rx_frame_buffer_pkg::*;
  localparam int DEPTH = 64;
  logic clock = 0, aresetn = 1;
  logic [7:0] s_tdata = 0;
  logic s_tvalid = 0, s_tready, s_tlast = 0, s_tuser = 0;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tready = 0, m_tlast, drop_pulse;
`ifdef RX_FRAME_BUFFER_STATS_EN
  logic [STAT_W-1:0] stat_ok, stat_err, stat_ovf;
`endif
  int checks = 0, fails = 0, drop_cnt = 0, stall_bad = 0;
  logic [8:0] exp_q[$], rx_q[$];
  bit rand_rdy = 0, rdy_fix = 0;
  bit prev_stall = 0;
  logic [8:0] prev_beat = 0;

  always #5 clock = ~clock;

  rx_frame_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .drop_pulse(drop_pulse)
`ifdef RX_FRAME_BUFFER_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err), .stat_ovf(stat_ovf)
`endif
  );

  initial forever begin
    @(posedge clock); #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // output monitor: records accepted beats, drop pulses and any change of data while stalled
  initial forever begin
    @(negedge clock);
    if (!aresetn) prev_stall = 0;
    else begin
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_beat)) stall_bad++;
      if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
      if (drop_pulse) drop_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_frame(input int len, input bit user, input bit gaps, input bit keep);
    logic [8:0] f[$];
    for (int i = 0; i < len; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin s_tvalid = 0; tick(); end
      s_tvalid = 1;
      s_tdata  = 8'($urandom);
      s_tlast  = (i == len - 1);
      s_tuser  = s_tlast ? user : 1'($urandom);
      f.push_back({s_tlast, s_tdata});
      tick();
    end
    s_tvalid = 0; s_tlast = 0; s_tuser = 0;
    if (keep) foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin tick(); n++; end
    repeat (8) tick();
  endtask

  task automatic test_reset();
    #2 aresetn = 0;
    repeat (3) tick();
    checks++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got %b exp 0", s_tready); end
    checks++; if ({m_tvalid, m_tlast, drop_pulse} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {m_tvalid, m_tlast, drop_pulse}); end
    checks++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL reset_m_tdata got %h exp 00", m_tdata); end
    aresetn = 1;
    tick(); tick();
    checks++; if (s_tready !== 1'b1) begin fails++; $display("FAIL reset_s_tready_after got %b exp 1", s_tready); end
  endtask

  task automatic test_good_frame();
    int lat = 0, d0 = drop_cnt;
    rdy_fix = 1; tick(); tick();
    send_frame(64, 0, 0, 1);
    while (!m_tvalid && lat < 10) begin tick(); lat++; end
    checks++; if (!m_tvalid || lat > 3) begin fails++; $display("FAIL good_latency got %0d cycles exp <=3", lat); end
    drain(300);
    checks++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL good_len got %0d exp %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL good_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt != d0) begin fails++; $display("FAIL good_drops got %0d exp %0d", drop_cnt - d0, 0); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_error_frame();
    int d0 = drop_cnt;
    send_frame(60, 1, 0, 0);
    send_frame(64, 0, 0, 1);
    drain(300);
    checks++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL err_len got %0d exp %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL err_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt - d0 != 1) begin fails++; $display("FAIL err_drops got %0d exp 1", drop_cnt - d0); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int d0 = drop_cnt;
    rdy_fix = 0; tick(); tick();
    send_frame(40, 0, 0, 1);
    send_frame(30, 0, 0, 0);
    repeat (5) tick();
    checks++; if (drop_cnt - d0 != 1) begin fails++; $display("FAIL ovf_drops got %0d exp 1", drop_cnt - d0); end
    checks++; if (rx_q.size() != 0) begin fails++; $display("FAIL ovf_stalled_out got %0d exp 0", rx_q.size()); end
    rdy_fix = 1;
    drain(300);
    checks++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL ovf_len got %0d exp %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    rx_q.delete(); exp_q.delete();
    d0 = drop_cnt;
    send_frame(DEPTH + 1, 0, 0, 0);
    repeat (10) tick();
    checks++; if (drop_cnt - d0 != 1 || rx_q.size() != 0) begin fails++; $display("FAIL ovf_long got drops %0d beats %0d exp 1 0", drop_cnt - d0, rx_q.size()); end
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0 = stall_bad;
    rand_rdy = 1;
    s_tvalid = 1; s_tdata = 8'hA5; s_tlast = 1; s_tuser = 0; tick();
    s_tdata = 8'h5A; tick();
    s_tvalid = 0; s_tlast = 0;
    exp_q = '{9'h1A5, 9'h15A};
    drain(200);
    checks++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_len got %0d exp 2", rx_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (stall_bad != s0) begin fails++; $display("FAIL b2b_stall_stable got %0d exp 0", stall_bad - s0); end
    rand_rdy = 0; rdy_fix = 1;
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    rdy_fix = 0; tick(); tick();
    send_frame(10, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin s_tvalid = 1; s_tdata = 8'($urandom); s_tlast = 0; tick(); end
    s_tvalid = 0;
    aresetn = 0; tick();
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got valid %b ready %b exp 0 0", m_tvalid, s_tready); end
    aresetn = 1; rdy_fix = 1;
    repeat (10) tick();
    checks++; if (rx_q.size() != 0) begin fails++; $display("FAIL rst_mid_lost got %0d beats exp 0", rx_q.size()); end
    send_frame(64, 0, 0, 1);
    drain(300);
    checks++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_mid_len got %0d exp %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_mid_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int d0 = drop_cnt, s0 = stall_bad, exp_drops = 0;
    rand_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 40), n = 0;
      bit user = ($urandom_range(0, 3) == 0);
      while (exp_q.size() - rx_q.size() + len > DEPTH && n < 2000) begin tick(); n++; end
      send_frame(len, user, 1, !user);
      exp_drops += int'(user);
    end
    drain(4000);
    checks++; if (rx_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_len got %0d exp %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (drop_cnt - d0 != exp_drops) begin fails++; $display("FAIL rand_drops got %0d exp %0d", drop_cnt - d0, exp_drops); end
    checks++; if (stall_bad != s0) begin fails++; $display("FAIL rand_stall_stable got %0d exp 0", stall_bad - s0); end
    rand_rdy = 0; rdy_fix = 1;
    rx_q.delete(); exp_q.delete();
  endtask

`ifdef RX_FRAME_BUFFER_STATS_EN
  task automatic test_stats();
    aresetn = 0; tick(); aresetn = 1; tick(); tick();
    checks++; if ({stat_ok, stat_err, stat_ovf} !== '0) begin fails++; $display("FAIL stats_reset got %h %h %h exp 0 0 0", stat_ok, stat_err, stat_ovf); end
    rdy_fix = 1;
    for (int i = 0; i < 3; i++) send_frame(10, 0, 0, 1);
    for (int i = 0; i < 2; i++) send_frame(12, 1, 0, 0);
    send_frame(DEPTH + 6, 0, 0, 0);
    drain(500);
    checks++; if (stat_ok !== 16'd3) begin fails++; $display("FAIL stats_ok got %0d exp 3", stat_ok); end
    checks++; if (stat_err !== 16'd2) begin fails++; $display("FAIL stats_err got %0d exp 2", stat_err); end
    checks++; if (stat_ovf !== 16'd1) begin fails++; $display("FAIL stats_ovf got %0d exp 1", stat_ovf); end
    rx_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_error_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef RX_FRAME_BUFFER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
